// File: rtl/rstxq_01a_if.sv
// Bus bundle for the transmit byte queue: the debug-side push/status
// signals and the serial-block TxStart/TxData/TxStatus handshake.
// Member names match the original port names of rstxq_01a.
interface rstxq_01a_if #(
    parameter int unsigned ADDR_W = 4
);
    // debug interface side
    logic              dbgif01a2rstxq01aWrEn;
    logic [7:0]        dbgif01a2rstxq01aWrData;
    logic              dbgif01a2rstxq01aFlush;
    logic              dbgif01a2rstxq01aErrClr;
    logic              rstxq01a2dbgif01aFull;
    logic              rstxq01a2dbgif01aEmpty;
    logic [ADDR_W:0]   rstxq01a2dbgif01aLevel;
    logic              rstxq01a2dbgif01aOvfErr;
    logic              rstxq01a2dbgif01aAckErr;
    // serial block side
    logic              rstxq01a2rsio_01aTxStart;
    logic [7:0]        rstxq01a2rsio_01aTxData;
    logic              rsio_01a2rstxq01aTxStatus;

    // seen from the queue itself
    modport slave (
        input  dbgif01a2rstxq01aWrEn,
        input  dbgif01a2rstxq01aWrData,
        input  dbgif01a2rstxq01aFlush,
        input  dbgif01a2rstxq01aErrClr,
        output rstxq01a2dbgif01aFull,
        output rstxq01a2dbgif01aEmpty,
        output rstxq01a2dbgif01aLevel,
        output rstxq01a2dbgif01aOvfErr,
        output rstxq01a2dbgif01aAckErr,
        output rstxq01a2rsio_01aTxStart,
        output rstxq01a2rsio_01aTxData,
        input  rsio_01a2rstxq01aTxStatus
    );

    // seen from the surrounding logic (debug interface + serial block)
    modport master (
        output dbgif01a2rstxq01aWrEn,
        output dbgif01a2rstxq01aWrData,
        output dbgif01a2rstxq01aFlush,
        output dbgif01a2rstxq01aErrClr,
        input  rstxq01a2dbgif01aFull,
        input  rstxq01a2dbgif01aEmpty,
        input  rstxq01a2dbgif01aLevel,
        input  rstxq01a2dbgif01aOvfErr,
        input  rstxq01a2dbgif01aAckErr,
        input  rstxq01a2rsio_01aTxStart,
        input  rstxq01a2rsio_01aTxData,
        output rsio_01a2rstxq01aTxStatus
    );
endinterface

// File: rtl/rstxq_01a.sv
// Transmit byte queue in front of the RS232-C serial block: buffers bytes
// pushed by the debug interface and paces them into the serial block's
// TxStart/TxData/TxStatus handshake, with level and sticky error reporting.
module rstxq_01a #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned ACK_TO = 64
) (
    input  logic         pavsv01a2rstxq01aRSClk,
    input  logic         pavsv01a2rstxq01aReset_n,
    rstxq_01a_if.slave   bus
);
    localparam int unsigned      DEPTH    = 1 << ADDR_W;
    localparam int unsigned      CNT_W    = (ACK_TO > 2) ? $clog2(ACK_TO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TO - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W:0]  LVL_FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic              ack_err_q, ack_err_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [CNT_W-1:0]  ack_cnt_q, ack_cnt_d;
    logic [7:0]        mem_q [DEPTH];

    logic              pop;
    logic              ack_set;
    logic              push_req;
    logic              push_ok;
    logic              ovf_set;

    // Transmit sequencer: pop into TxData, pulse TxStart, then track TxStatus
    always_comb begin
        state_d    = state_q;
        ack_cnt_d  = ack_cnt_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        pop        = 1'b0;
        ack_set    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_q && !bus.rsio_01a2rstxq01aTxStatus) begin
                    pop        = 1'b1;
                    tx_data_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
                    tx_start_d = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                ack_cnt_d = '0;
                state_d   = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.rsio_01a2rstxq01aTxStatus) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    ack_cnt_d = ack_cnt_q + CNT_ONE;
                    if (ack_cnt_d == CNT_LAST) begin
                        // byte is abandoned, no retry
                        ack_set = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.rsio_01a2rstxq01aTxStatus) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO pointers, level/flags and sticky error flags
    always_comb begin
        push_req = bus.dbgif01a2rstxq01aWrEn && !bus.dbgif01a2rstxq01aFlush;
        // a same-cycle pop frees the slot, so a push while full is still taken
        push_ok  = push_req && (!full_q || pop);
        ovf_set  = push_req && full_q && !pop;
        if (bus.dbgif01a2rstxq01aFlush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, push_ok};
            rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, pop};
        end
        level_d = wr_ptr_d - rd_ptr_d;
        full_d  = (level_d == LVL_FULL);
        empty_d = (level_d == '0);
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (bus.dbgif01a2rstxq01aErrClr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (ack_set) begin
            ack_err_d = 1'b1;
        end else if (bus.dbgif01a2rstxq01aErrClr) begin
            ack_err_d = 1'b0;
        end else begin
            ack_err_d = ack_err_q;
        end
    end

    // State and output registers
    always_ff @(posedge pavsv01a2rstxq01aRSClk or negedge pavsv01a2rstxq01aReset_n) begin
        if (!pavsv01a2rstxq01aReset_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            ack_err_q  <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            ack_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ovf_q      <= ovf_d;
            ack_err_q  <= ack_err_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            ack_cnt_q  <= ack_cnt_d;
        end
    end

    // Byte storage; contents are don't-care until written
    always_ff @(posedge pavsv01a2rstxq01aRSClk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.dbgif01a2rstxq01aWrData;
        end
    end

    assign bus.rstxq01a2dbgif01aFull    = full_q;
    assign bus.rstxq01a2dbgif01aEmpty   = empty_q;
    assign bus.rstxq01a2dbgif01aLevel   = level_q;
    assign bus.rstxq01a2dbgif01aOvfErr  = ovf_q;
    assign bus.rstxq01a2dbgif01aAckErr  = ack_err_q;
    assign bus.rstxq01a2rsio_01aTxStart = tx_start_q;
    assign bus.rstxq01a2rsio_01aTxData  = tx_data_q;
endmodule

// File: tb/tb_rstxq_01a.sv
// Bench for rstxq_01a: directed pushes, a simple transmitter model, and a
// scoreboard of expected transmitted bytes checked on every TxStart.
module tb_rstxq_01a;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned ACK_TO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rstxq_01a_if #(.ADDR_W(ADDR_W)) ifc ();

    rstxq_01a #(.ADDR_W(ADDR_W), .ACK_TO(ACK_TO)) dut (
        .pavsv01a2rstxq01aRSClk   (clk),
        .pavsv01a2rstxq01aReset_n (rst_n),
        .bus                      (ifc.slave)
    );

    logic            full, empty, ovf, ackerr, txstart, txstatus;
    logic [ADDR_W:0] level;
    logic [7:0]      txdata;
    assign full    = ifc.rstxq01a2dbgif01aFull;
    assign empty   = ifc.rstxq01a2dbgif01aEmpty;
    assign level   = ifc.rstxq01a2dbgif01aLevel;
    assign ovf     = ifc.rstxq01a2dbgif01aOvfErr;
    assign ackerr  = ifc.rstxq01a2dbgif01aAckErr;
    assign txstart = ifc.rstxq01a2rsio_01aTxStart;
    assign txdata  = ifc.rstxq01a2rsio_01aTxData;

    int total = 0;
    int bad = 0;
    int starts = 0;
    int cyc = 0;
    logic [7:0] exp_q [$];

    // transmitter model: 0 = responds to TxStart, 1 = forced busy, 2 = never acks
    int   tx_mode = 0;
    int   hold = 100;
    int   hold_left = 0;
    logic model_busy = 1'b0;
    logic pend = 1'b0;
    assign ifc.rsio_01a2rstxq01aTxStatus = (tx_mode == 1) ? 1'b1 :
                                           (tx_mode == 2) ? 1'b0 : model_busy;
    assign txstatus = ifc.rsio_01a2rstxq01aTxStatus;

    always @(posedge clk) cyc++;

    // model raises busy one cycle after TxStart and holds it for 'hold' cycles
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
            model_busy = 1'b0;
            hold_left = 0;
        end else begin
            if (pend) begin
                model_busy = 1'b1;
                hold_left = hold;
                pend = 1'b0;
            end else if (model_busy) begin
                hold_left--;
                if (hold_left <= 0) model_busy = 1'b0;
            end
            if (txstart) pend = 1'b1;
        end
    end

    // scoreboard monitor: every TxStart must carry the next expected byte
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (rst_n && txstart) begin
            starts++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL tx_unexpected: got TxStart with %02h, required no TxStart", txdata);
            end else begin
                exp_b = exp_q.pop_front();
                if (txdata !== exp_b) begin
                    bad++;
                    $display("FAIL tx_byte: got %02h, required %02h", txdata, exp_b);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // called at a negedge; holds WrEn for one cycle
    task automatic push_b(input logic [7:0] b, input bit keep);
        ifc.dbgif01a2rstxq01aWrEn = 1'b1;
        ifc.dbgif01a2rstxq01aWrData = b;
        if (keep) exp_q.push_back(b);
        @(negedge clk);
        ifc.dbgif01a2rstxq01aWrEn = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 0);
    endtask

    task automatic finish_tx(input string name);
        int n = 0;
        tick(2);
        while (txstatus && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(txstatus), 0);
        tick(3);
    endtask

    task automatic err_clear;
        ifc.dbgif01a2rstxq01aErrClr = 1'b1;
        @(negedge clk);
        ifc.dbgif01a2rstxq01aErrClr = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cs;
        int s0;
        int bad_hold;
        ifc.dbgif01a2rstxq01aWrEn   = 1'b0;
        ifc.dbgif01a2rstxq01aWrData = 8'h00;
        ifc.dbgif01a2rstxq01aFlush  = 1'b0;
        ifc.dbgif01a2rstxq01aErrClr = 1'b0;
        tick(3);
        check("rst_level", 32'(level), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_flags", 32'({ovf, ackerr}), 0);
        check("rst_txstart", 32'(txstart), 0);
        check("rst_txdata", 32'(txdata), 0);
        rst_n = 1'b1;
        tick(1);

        // single byte, latency and pulse width
        hold = 100;
        push_b(8'hA5, 1'b1);
        check("t1_level1", 32'(level), 1);
        check("t1_nostart_n1", 32'(txstart), 0);
        tick(1);
        check("t1_start_n2", 32'(txstart), 1);
        check("t1_data_n2", 32'(txdata), 32'h A5);
        check("t1_empty", 32'(empty), 1);
        tick(1);
        check("t1_pulse_width", 32'(txstart), 0);
        bad_hold = 0;
        for (int i = 0; i < 99; i++) begin
            @(negedge clk);
            if (txdata !== 8'hA5 || txstart !== 1'b0) bad_hold++;
        end
        check("t1_data_hold", 32'(bad_hold), 0);
        check("t1_busy_held", 32'(txstatus), 1);
        finish_tx("t1_txdone");
        check("t1_flags", 32'({ovf, ackerr}), 0);
        check("t1_level0", 32'(level), 0);

        // ordering and overflow
        hold = 3;
        tx_mode = 1;
        tick(1);
        for (int i = 0; i < 17; i++) push_b(8'(i), i < 16);
        check("t2_level16", 32'(level), 16);
        check("t2_full", 32'(full), 1);
        check("t2_ovf", 32'(ovf), 1);
        tx_mode = 0;
        wait_drain("t2_drain", 400);
        finish_tx("t2_txdone");
        check("t2_empty", 32'(empty), 1);
        err_clear();
        check("t2_ovf_clr", 32'(ovf), 0);

        // push while full with same-cycle pop
        tx_mode = 1;
        tick(1);
        for (int i = 0; i < 16; i++) push_b(8'h20 + 8'(i), 1'b1);
        check("t3_full", 32'(full), 1);
        tx_mode = 0;
        push_b(8'h55, 1'b1);
        check("t3_level", 32'(level), 16);
        check("t3_full_kept", 32'(full), 1);
        check("t3_no_ovf", 32'(ovf), 0);
        wait_drain("t3_drain", 400);
        finish_tx("t3_txdone");
        check("t3_empty", 32'(empty), 1);
        check("t3_no_ovf_end", 32'(ovf), 0);

        // ack timeout
        tx_mode = 2;
        push_b(8'h3C, 1'b1);
        n = 0;
        while (!txstart && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t4_start_seen", 32'(txstart), 1);
        cs = cyc;
        n = 0;
        while (!ackerr && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t4_ackerr_set", 32'(ackerr), 1);
        check("t4_ack_latency", 32'(cyc - cs), ACK_TO);
        tx_mode = 0;
        push_b(8'h3D, 1'b1);
        wait_drain("t4_next_byte", 20);
        finish_tx("t4_txdone");
        check("t4_ackerr_sticky", 32'(ackerr), 1);
        err_clear();
        check("t4_ackerr_clr", 32'(ackerr), 0);

        // flush during transmit
        hold = 10;
        for (int i = 0; i < 5; i++) push_b(8'h61 + 8'(i), 1'b1);
        n = 0;
        while (!txstatus && n < 20) begin
            @(negedge clk);
            n++;
        end
        tick(2);
        check("t5_in_wait_done", 32'(txstatus), 1);
        ifc.dbgif01a2rstxq01aFlush  = 1'b1;
        ifc.dbgif01a2rstxq01aWrEn   = 1'b1;
        ifc.dbgif01a2rstxq01aWrData = 8'h77;
        exp_q.delete();
        @(negedge clk);
        ifc.dbgif01a2rstxq01aFlush = 1'b0;
        ifc.dbgif01a2rstxq01aWrEn  = 1'b0;
        check("t5_level0", 32'(level), 0);
        check("t5_empty", 32'(empty), 1);
        check("t5_no_ovf", 32'(ovf), 0);
        s0 = starts;
        tick(30);
        check("t5_no_start", 32'(starts - s0), 0);
        check("t5_byte1_done", 32'(txstatus), 0);
        check("t5_txdata_kept", 32'(txdata), 32'h61);

        // asynchronous reset mid-WAIT_BUSY
        tx_mode = 2;
        for (int i = 0; i < 4; i++) push_b(8'h81 + 8'(i), i == 0);
        check("t6_queued", 32'(level), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_level", 32'(level), 0);
        check("t6_rst_empty", 32'(empty), 1);
        check("t6_rst_txdata", 32'(txdata), 0);
        check("t6_rst_txstart", 32'(txstart), 0);
        check("t6_rst_flags", 32'({full, ovf, ackerr}), 0);
        exp_q.delete();
        tick(3);
        rst_n = 1'b1;
        tx_mode = 0;
        s0 = starts;
        tick(20);
        check("t6_post_empty", 32'(empty), 1);
        check("t6_post_nostart", 32'(starts - s0), 0);
        check("t6_post_ackerr", 32'(ackerr), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rstxq_01a.md
Name: rstxq_01a

Overview:
- Transmit byte queue directly upstream of the RS232-C serial I/O block.
- Accepts bytes from the debug interface (dbgif01a) at core rate and buffers them in a FIFO.
- Paces bytes into the serial block's TxStart/TxData/TxStatus handshake, so dbgif01a never polls transmitter status per byte.
- Reports FIFO level, overflow and transmitter-acknowledge errors.

Parameters:
ADDR_W, 4, FIFO address width; depth = 2**ADDR_W entries (16).
ACK_TO, 64, clock cycles allowed between a TxStart pulse and TxStatus rising.

Ports:
pavsv01a2rstxq01aRSClk  input  1  RS clock; the only clock, same clock as the serial block.
pavsv01a2rstxq01aReset_n  input  1  reset, asynchronous, active-low.
dbgif01a2rstxq01aWrEn  input  1  push strobe, one byte per high cycle.
dbgif01a2rstxq01aWrData  input  8  byte to push.
dbgif01a2rstxq01aFlush  input  1  synchronous FIFO clear.
dbgif01a2rstxq01aErrClr  input  1  clears both sticky error flags.
rstxq01a2dbgif01aFull  output  1  FIFO holds 2**ADDR_W entries.
rstxq01a2dbgif01aEmpty  output  1  FIFO holds 0 entries.
rstxq01a2dbgif01aLevel  output  ADDR_W+1  entry count, 0..2**ADDR_W.
rstxq01a2dbgif01aOvfErr  output  1  sticky: a push was dropped.
rstxq01a2dbgif01aAckErr  output  1  sticky: transmitter did not acknowledge within ACK_TO.
rstxq01a2rsio_01aTxStart  output  1  one-cycle transmit request to the serial block.
rstxq01a2rsio_01aTxData  output  8  byte being transmitted.
rsio_01a2rstxq01aTxStatus  input  1  transmitter busy (1 = shifting a byte).

Behaviour:
- Clocking and reset: one clock, pavsv01a2rstxq01aRSClk. Reset pavsv01a2rstxq01aReset_n is asynchronous, active-low.
- Reset values: Full=0, Empty=1, Level=0, OvfErr=0, AckErr=0, TxStart=0, TxData=8'h00. Pointers=0, FSM=IDLE, ack counter=0.
- All outputs are registered.
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr of ADDR_W+1 bits; both wrap modulo 2**(ADDR_W+1).
  - Level = wr_ptr - rd_ptr.
  - Full and Empty are derived from Level.
- Push rules:
  - WrEn with not Full: store the byte; Level increments next cycle.
  - WrEn while Full and no pop that cycle: byte dropped, OvfErr set, Level unchanged.
  - WrEn while Full with a pop in the same cycle: byte accepted, Level unchanged.
- Flush: next cycle pointers=0 and Level=0.
  - Flush wins over a same-cycle WrEn; the write is dropped and OvfErr is not set.
  - Flush does not abort a byte already loaded into TxData; the FSM completes that byte normally.
- Error flags: ErrClr clears OvfErr and AckErr next cycle. A same-cycle set wins over clear.
- FSM states:
  - IDLE: if not Empty and TxStatus=0, pop the head into TxData and go to START.
  - START: TxStart=1 for exactly this one cycle; clear the ack counter; go to WAIT_BUSY.
  - WAIT_BUSY: if TxStatus=1, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches ACK_TO-1, set AckErr and go to IDLE; the byte is considered lost and is not retried.
  - WAIT_DONE: when TxStatus=0, go to IDLE.
- TxData holds stable from the pop until the next pop. It is never changed while in START, WAIT_BUSY or WAIT_DONE.
- Latency: with empty FIFO, IDLE and TxStatus=0, a push in cycle N gives TxData valid at cycle N+2 and TxStart high in cycle N+2.
- Back-to-back bytes: minimum 2 cycles between the TxStatus falling edge and the next TxStart (IDLE decision plus START).
- TxStatus high while in IDLE (e.g. another source driving the transmitter): hold in IDLE, no pop.
- Reset mid-operation: all state returns to reset values immediately. The queued bytes and any in-flight TxStart are lost.

Test Plan:
- Single byte: push 8'hA5 at cycle 0; model transmitter raises TxStatus 1 cycle after TxStart and holds it 100 cycles -> TxStart pulse of width 1 at cycle 2, TxData=8'hA5 through cycle 103, Level returns 1->0, Empty=1, no error flags.
- Ordering and full: push 17 bytes 8'h00..8'h10 with TxStatus forced high -> Level reaches 16, Full=1, byte 8'h10 dropped, OvfErr=1. Release TxStatus -> bytes 8'h00..8'h0F transmitted in order.
- Push while full with a same-cycle pop: FIFO full, TxStatus falls, push 8'h55 in the pop cycle -> accepted, OvfErr stays 0, 8'h55 transmitted last.
- Ack timeout: push 8'h3C with TxStatus tied low -> AckErr=1 exactly ACK_TO cycles after START, FSM returns to IDLE. Next byte 8'h3D is still issued. ErrClr -> AckErr=0.
- Flush during transmit: queue 5 bytes, assert Flush while in WAIT_DONE on byte 1 -> byte 1 completes, Level=0 next cycle, no further TxStart. A push in the Flush cycle is dropped with OvfErr=0.
- Async reset: assert Reset_n low mid-WAIT_BUSY with 3 bytes queued -> outputs at reset values without a clock edge. After release, Empty=1 and no TxStart.
